// File: rtl/branch_unit.sv
// branch_unit: resolves JR/JPC/BRFL/CALL/RET branch targets and keeps a
// circular return-address stack (RAS) for CALL/RET.
// Latency: target/taken/target_valid are registered one clock after instr_valid.
// Ports: clk, rst (async active-high); instr_valid/instr/addr/immediate/rd/flag in;
//   flush empties the stack, err_clr clears sticky errors;
//   target/target_valid/taken, full/empty/count, ovf_err/udf_err out.
// Config: define BRANCH_RAS_WRAP_EN to make CALL-on-full overwrite the oldest
//   entry; otherwise the push is dropped and ovf_err is set.
module branch_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 15,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  input  logic [DWIDTH-1:0]          instr,
  input  logic [AWIDTH-1:0]          addr,
  input  logic [DWIDTH-1:0]          immediate,
  input  logic [DWIDTH-1:0]          rd,
  input  logic                       flag,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic [DWIDTH-1:0]          target,
  output logic                       target_valid,
  output logic                       taken,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [4:0] OP_JR   = 5'b01101;
  localparam logic [4:0] OP_JPC  = 5'b01110;
  localparam logic [4:0] OP_BRFL = 5'b01111;
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET  = 5'b10001;

  // Stack storage is not reset; validity is tracked solely by cnt.
  logic [AWIDTH-1:0] ras [DEPTH];
  logic [PW-1:0]     ptr;      // next free slot; top of stack is ptr-1
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     top_idx;
  logic [4:0]        opcode;
  logic              unused_instr_bits;

  logic              dec_vld;
  logic              dec_taken;
  logic [DWIDTH-1:0] dec_target;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;
  logic              udf_evt;

  assign opcode            = instr[DWIDTH-1:DWIDTH-5];
  assign unused_instr_bits = ^instr[DWIDTH-6:0];
  assign top_idx           = ptr - PW'(1);

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Decode. flush squashes the instruction entirely: no output pulse,
  // no stack movement and no error events.
  always_comb begin
    dec_vld    = 1'b0;
    dec_taken  = 1'b0;
    dec_target = '0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_evt    = 1'b0;
    udf_evt    = 1'b0;
    if (instr_valid && !flush) begin
      case (opcode)
        OP_JR: begin
          dec_vld    = 1'b1;
          dec_taken  = 1'b1;
          dec_target = rd;
        end
        OP_JPC: begin
          dec_vld    = 1'b1;
          dec_taken  = 1'b1;
          dec_target = immediate + rd + DWIDTH'(1);
        end
        OP_BRFL: begin
          dec_vld    = 1'b1;
          dec_taken  = flag;
          dec_target = rd;
        end
        OP_CALL: begin
          dec_vld    = 1'b1;
          dec_taken  = 1'b1;
          dec_target = rd;
          if (!full) begin
            do_push = 1'b1;
          end else begin
`ifdef BRANCH_RAS_WRAP_EN
            // When full, ptr points at the oldest entry, so pushing
            // overwrites it and the count stays at DEPTH.
            do_push = 1'b1;
`else
            ovf_evt = 1'b1;
`endif
          end
        end
        OP_RET: begin
          dec_vld = 1'b1;
          if (!empty) begin
            do_pop     = 1'b1;
            dec_taken  = 1'b1;
            dec_target = DWIDTH'(ras[top_idx]);
          end else begin
            udf_evt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target       <= '0;
      target_valid <= 1'b0;
      taken        <= 1'b0;
      ptr          <= '0;
      cnt          <= '0;
      ovf_err      <= 1'b0;
      udf_err      <= 1'b0;
    end else begin
      target_valid <= dec_vld;
      taken        <= dec_taken;
      if (dec_vld) begin
        target <= dec_target;
      end

      if (flush) begin
        ptr <= '0;
        cnt <= '0;
      end else if (do_push) begin
        ptr <= ptr + PW'(1);
        if (!full) begin
          cnt <= cnt + CW'(1);
        end
      end else if (do_pop) begin
        ptr <= top_idx;
        cnt <= cnt - CW'(1);
      end

      // A new error event takes priority over a concurrent clear.
      ovf_err <= ovf_evt | (ovf_err & ~err_clr);
      udf_err <= udf_evt | (udf_err & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      ras[ptr] <= addr;
    end
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, instruction/operand/target width.
REQ-002 SHALL have parameter AWIDTH, default 15, return-address width.
REQ-003 SHALL have parameter DEPTH, default 32, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have ports: clk  in  1  clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: instr_valid  in  1  instr qualifies this cycle; instr  in  DWIDTH  opcode in instr[DWIDTH-1:DWIDTH-5].
REQ-007 SHALL have ports: addr  in  AWIDTH  return address to push; immediate  in  DWIDTH; rd  in  DWIDTH; flag  in  1  BRFL condition.
REQ-008 SHALL have ports: flush  in  1  empty stack; err_clr  in  1  clear sticky errors.
REQ-009 SHALL have ports: target  out  DWIDTH; target_valid  out  1; taken  out  1; full  out  1; empty  out  1; count  out  $clog2(DEPTH+1).
REQ-010 SHALL have ports: ovf_err  out  1  sticky overflow; udf_err  out  1  sticky underflow.

Function
REQ-011 SHALL decode opcodes JR=01101, JPC=01110, BRFL=01111, CALL=10000, RET=10001; all others are non-branch.
REQ-012 SHALL register target, target_valid, taken one clock after the edge sampling instr_valid=1 (latency 1); target_valid is a 1-cycle pulse.
REQ-013 SHALL for JR: target=rd, taken=1.
REQ-014 SHALL for JPC: target=(immediate+rd+1) mod 2^DWIDTH, taken=1.
REQ-015 SHALL for BRFL: target=rd, taken=flag.
REQ-016 SHALL for CALL: push addr, target=rd, taken=1.
REQ-017 SHALL for RET when not empty: pop, target=top entry zero-extended to DWIDTH, taken=1.
REQ-018 SHALL for RET when empty: no pop, target=0, taken=0, target_valid=1, set udf_err.
REQ-019 SHALL for non-branch opcode or instr_valid=0: target_valid=0, taken=0, target held, stack unchanged.
REQ-020 SHALL keep count=number of valid entries; full=(count==DEPTH); empty=(count==0); all registered-state derived.
REQ-021 SHALL on flush=1: count becomes 0 next edge, concurrent instruction discarded (target_valid=0, no push/pop, no error set).
REQ-022 SHALL on err_clr=1 clear ovf_err and udf_err; an error event in the same cycle wins (flag set).
REQ-023 SHALL implement the stack as circular buffer with wrap-around pointer modulo DEPTH.

Reset
REQ-024 SHALL on rst=1 immediately force target=0, target_valid=0, taken=0, count=0, empty=1, full=0, ovf_err=0, udf_err=0, pointer=0.
REQ-025 SHALL not require stack storage to be reset; reset mid-operation discards all entries.
REQ-026 SHALL resume decoding on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL use macro BRANCH_RAS_WRAP_EN selecting CALL-when-full behaviour.
REQ-028 SHALL with BRANCH_RAS_WRAP_EN defined: CALL on full overwrites oldest entry, count stays DEPTH, ovf_err unchanged, target=rd, taken=1.
REQ-029 SHALL with BRANCH_RAS_WRAP_EN undefined: CALL on full drops the push, stack unchanged, ovf_err set, target=rd, taken=1.

Verification
REQ-030 SHALL cover: JPC immediate=0x10, rd=0x100 -> next cycle target=0x111, taken=1, target_valid=1.
REQ-031 SHALL cover: BRFL rd=0x40 with flag=0 then flag=1 -> taken=0 then taken=1, target=0x40 both.
REQ-032 SHALL cover: CALL addr=0x5,0x6,0x7 then 3xRET -> targets 0x7,0x6,0x5, count 3->0, empty=1.
REQ-033 SHALL cover: RET on empty -> target=0, taken=0, udf_err=1; err_clr -> udf_err=0.
REQ-034 SHALL cover: DEPTH+1 CALLs addr=1..DEPTH+1 then DEPTH RETs -> WRAP_EN: DEPTH+1..2, ovf_err=0; else: DEPTH..1, ovf_err=1.
REQ-035 SHALL cover: rst pulse between clock edges with count=3 -> outputs and count zero immediately; flush+CALL same cycle -> count=0, target_valid=0.
